psram_qspi_responder: RTL and testbench
=======================================

Name: psram_qspi_responder

Overview:
- Device-side (responder) end of the quad-SPI/QPI PSRAM link driven by the team's PSRAM controller.
- Decodes command, address, dummy and data phases from sck/ce_n/sio_in and drives read data on sio_out.
- Turns each completed byte into a single-cycle access on a byte-wide synchronous memory port.
- Used as a synthesizable PSRAM stand-in for FPGA bring-up and as the bench responder for the controller.

Parameters:
- ADDR_W, 24, byte address width; the address counter wraps modulo 2^ADDR_W.
- WAIT_CYCLES, 6, dummy sck cycles between the last address nibble and the first data nibble of 0xEB.
- SYNC_STAGES, 2, synchronizer depth on sck, ce_n and sio_in (minimum 2).

Ports:
- HCLK  in  1  system clock; must run at least 4x the sck frequency.
- HRESETn  in  1  asynchronous active-low reset.
- sck  in  1  serial clock from the controller.
- ce_n  in  1  chip enable, active low.
- sio_in  in  4  controller dout; SPI MOSI is bit 0.
- sio_out  out  4  to controller din; SPI MISO is bit 1.
- sio_outen  out  4  per-bit output enable.
- qpi_mode  out  1  current mode flag: 1 = QPI.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-HCLK write strobe.
- mem_re  out  1  one-HCLK read strobe.
- mem_rdata  in  8  read data, valid 1 HCLK after mem_re.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values: sio_out=0, sio_outen=0, qpi_mode=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0. State is IDLE.
- Input sampling: sck, ce_n and sio_in pass through SYNC_STAGES flops.
  - Rising sck edge is detected as synced sck 0->1; input bits are sampled on that edge.
  - Falling sck edge (1->0) is used to update sio_out.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD on synced ce_n falling.
- CMD collects 8 bits. SPI mode: 1 bit per edge on sio_in[0]. QPI mode: 1 nibble per edge, high nibble first.
- Command decode at the 8th bit or 2nd nibble:
  - 0x03 (SPI mode only): serial read, serial address, no dummy.
  - 0x02 (SPI mode): serial write with serial address. In QPI mode 0x02 is a quad write.
  - 0x38: quad write; address and data are quad.
  - 0xEB: quad read; quad address, then WAIT_CYCLES dummy cycles, then quad data.
  - 0x35: set qpi_mode; only valid in SPI mode.
  - 0xF5: clear qpi_mode; only valid in QPI mode.
  - Anything else, or a mode-invalid code (0x03 in QPI, 0x35 in QPI, 0xF5 in SPI) -> IGNORE until ce_n rises.
- Mode-switch timing: 0x35/0xF5 update qpi_mode on the decode cycle. The new mode applies from the next ce_n low.
- ADDR: 24 address bits MSB first, serial or quad per command. mem_addr takes the low ADDR_W bits.
- Read path:
  - mem_re pulses on the HCLK the address completes, and again right after each byte's final output bit is driven.
  - The fetched byte is latched into the shift register on the following cycle.
  - The address post-increments after each read and wraps from 2^ADDR_W-1 to 0.
- RDATA output timing:
  - The first bit or nibble is driven on the sck falling edge that follows the last address (0x03) or last dummy (0xEB) rising edge.
  - Quad reads send the high nibble first. Serial reads send MSB first on sio_out[1].
  - sio_outen = 4'b0010 for serial reads, 4'hF for quad reads, held until ce_n high.
- WDATA: bytes are assembled MSB or high nibble first. mem_we pulses with mem_wdata and mem_addr 1 HCLK after a byte completes. The address then increments and wraps.
- ce_n rising in any state:
  - Return to IDLE, sio_outen=0, sio_out=0.
  - A partial write byte is discarded, with no mem_we.
  - A pending mem_re completes but its data is dropped.
- sck edges while ce_n is high are ignored.
- Reset mid-transfer aborts immediately to the reset values; no memory strobe is issued.
- mem_we and mem_re are never asserted in the same cycle.

Decomposition:
- Package psram_pkg:
  - command code constants (0x03, 0x02, 0x38, 0xEB, 0x35, 0xF5);
  - state enum;
  - the SPI output-enable constant 4'b0010 and the quad output-enable constant 4'hF.
- One sub-module, psram_sck_sync: the SYNC_STAGES synchronizer plus sck rise/fall and ce_n fall/rise pulse generation.

Test Plan:
- Serial write, then serial read:
  - Stimulus: SPI mode, 0x02, addr 0x000010, data 0xA5 0x3C; then 0x03, addr 0x000010, 2 bytes.
  - Response: mem_we at 0x10=0xA5 and 0x11=0x3C; the read shifts out 0xA5 0x3C on sio_out[1] with sio_outen=4'b0010.
- Quad read with dummy cycles:
  - Stimulus: memory preloaded 0x100=0x12, 0x101=0x34; 0xEB, addr 0x000100.
  - Response: exactly 6 dummy sck cycles, then nibbles 1,2,3,4 on sio_out with sio_outen=4'hF.
- QPI entry and exit:
  - Stimulus: 0x35 serial, then 0x38 as two nibbles with addr 0x000020, data 0x5A; then 0xF5 in QPI.
  - Response: qpi_mode=1 after 0x35; mem_we at 0x20=0x5A; qpi_mode=0 after 0xF5.
- Address wrap:
  - Stimulus: quad write of 3 bytes starting at 0xFFFFFF.
  - Response: mem_we addresses are 0xFFFFFF, 0x000000, 0x000001.
- Abort:
  - Stimulus: ce_n deasserted after 1 nibble of a write byte, or mid-read.
  - Response: no mem_we; sio_outen=0 within SYNC_STAGES+1 HCLK; the next transaction decodes normally.
- Illegal command:
  - Stimulus: command 0x9F, then an 8-byte burst.
  - Response: no mem_we, no mem_re, sio_outen stays 0, and the block returns to IDLE on ce_n high.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared constants and types for the PSRAM QSPI/QPI responder.
// Command codes, FSM states and output-enable patterns.
package psram_pkg;

    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_QWRITE  = 8'h38;
    localparam logic [7:0] CMD_QREAD   = 8'hEB;
    localparam logic [7:0] CMD_QPI_ON  = 8'h35;
    localparam logic [7:0] CMD_QPI_OFF = 8'hF5;

    localparam logic [3:0] OE_SPI  = 4'b0010;
    localparam logic [3:0] OE_QUAD = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    // Index of the final sck edge of a phase carrying 'bits' bits.
    function automatic logic [7:0] last_beat(
        input logic       wide,
        input logic [7:0] bits
    );
        return wide ? (bits >> 2) - 8'd1 : bits - 8'd1;
    endfunction

endpackage

// File: rtl/psram_sck_sync.sv
// Synchronizes sck, ce_n and sio_in into HCLK and derives edge pulses.
// sck pulses are suppressed while the synced ce_n is high.
module psram_sck_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_fall,
    output logic       ce_rise
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] ce_q;
    logic [3:0]             sio_q [SYNC_STAGES];
    logic                   sck_p;
    logic                   ce_p;
    logic                   sck_s;
    logic                   ce_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= '0;
            ce_q  <= '1;
            sck_p <= 1'b0;
            ce_p  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sio_q[i] <= '0;
            end
        end else begin
            sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
            ce_q     <= {ce_q[SYNC_STAGES-2:0], ce_n};
            sio_q[0] <= sio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sio_q[i] <= sio_q[i-1];
            end
            sck_p <= sck_s;
            ce_p  <= ce_s;
        end
    end

    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign ce_s     = ce_q[SYNC_STAGES-1];
    assign sio      = sio_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_p & ~ce_s;
    assign sck_fall = ~sck_s & sck_p & ~ce_s;
    assign ce_fall  = ~ce_s & ce_p;
    assign ce_rise  = ce_s & ~ce_p;

endmodule

// File: rtl/psram_qspi_responder.sv
// PSRAM device-side QSPI/QPI responder: decodes the serial link into
// single-cycle accesses on a byte-wide synchronous memory port.
module psram_qspi_responder
    import psram_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              sck,
    input  logic              ce_n,
    input  logic [3:0]        sio_in,
    output logic [3:0]        sio_out,
    output logic [3:0]        sio_outen,
    output logic              qpi_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    logic [3:0] sio;
    logic       sck_rise;
    logic       sck_fall;
    logic       ce_fall;
    logic       ce_rise;

    psram_sck_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .sck     (sck),
        .ce_n    (ce_n),
        .sio_in  (sio_in),
        .sio     (sio),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .ce_fall (ce_fall),
        .ce_rise (ce_rise)
    );

    state_t            state, state_d;
    logic              qpi_d;
    logic [7:0]        cnt, cnt_d;
    logic [23:0]       sreg, sreg_d;
    logic              quad, quad_d;
    logic              rd, rd_d;
    logic              dmy, dmy_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;
    logic              we_d, re_d;
    logic [3:0]        out_d, oen_d;
    logic [7:0]        obyte, obyte_d;
    logic [2:0]        ocnt, ocnt_d;
    logic              re_dly;

    logic              wide;
    logic [23:0]       sh_next;
    logic [7:0]        code;
    logic [7:0]        cur;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            qpi_mode  <= 1'b0;
            cnt       <= '0;
            sreg      <= '0;
            quad      <= 1'b0;
            rd        <= 1'b0;
            dmy       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            sio_out   <= '0;
            sio_outen <= '0;
            obyte     <= '0;
            ocnt      <= '0;
            re_dly    <= 1'b0;
        end else begin
            state     <= state_d;
            qpi_mode  <= qpi_d;
            cnt       <= cnt_d;
            sreg      <= sreg_d;
            quad      <= quad_d;
            rd        <= rd_d;
            dmy       <= dmy_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_we    <= we_d;
            mem_re    <= re_d;
            sio_out   <= out_d;
            sio_outen <= oen_d;
            obyte     <= obyte_d;
            ocnt      <= ocnt_d;
            re_dly    <= mem_re;
        end
    end

    // Command phase width follows the link mode; later phases follow the command.
    assign wide    = (state == CMD) ? qpi_mode : quad;
    assign sh_next = wide ? {sreg[19:0], sio} : {sreg[22:0], sio[0]};
    assign code    = sh_next[7:0];
    // Read data may be needed on the same cycle it returns from memory.
    assign cur     = re_dly ? mem_rdata : obyte;

    always_comb begin
        state_d = state;
        qpi_d   = qpi_mode;
        cnt_d   = cnt;
        sreg_d  = sreg;
        quad_d  = quad;
        rd_d    = rd;
        dmy_d   = dmy;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 1'b0;
        re_d    = 1'b0;
        out_d   = sio_out;
        oen_d   = sio_outen;
        obyte_d = cur;
        ocnt_d  = ocnt;

        if (mem_we || mem_re) begin
            addr_d = mem_addr + ADDR_W'(1);
        end

        if (ce_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
            ocnt_d  = '0;
            out_d   = '0;
            oen_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ce_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        sreg_d = sh_next;
                        cnt_d  = cnt + 8'd1;
                        if (cnt == last_beat(qpi_mode, 8'd8)) begin
                            cnt_d   = '0;
                            state_d = IGNORE;
                            unique case (1'b1)
                                (code == CMD_READ) && !qpi_mode: begin
                                    state_d = ADDR;
                                    quad_d  = 1'b0;
                                    rd_d    = 1'b1;
                                    dmy_d   = 1'b0;
                                end
                                code == CMD_WRITE: begin
                                    state_d = ADDR;
                                    quad_d  = qpi_mode;
                                    rd_d    = 1'b0;
                                    dmy_d   = 1'b0;
                                end
                                code == CMD_QWRITE: begin
                                    state_d = ADDR;
                                    quad_d  = 1'b1;
                                    rd_d    = 1'b0;
                                    dmy_d   = 1'b0;
                                end
                                code == CMD_QREAD: begin
                                    state_d = ADDR;
                                    quad_d  = 1'b1;
                                    rd_d    = 1'b1;
                                    dmy_d   = (WAIT_CYCLES != 0);
                                end
                                (code == CMD_QPI_ON) && !qpi_mode: begin
                                    qpi_d = 1'b1;
                                end
                                (code == CMD_QPI_OFF) && qpi_mode: begin
                                    qpi_d = 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        sreg_d = sh_next;
                        cnt_d  = cnt + 8'd1;
                        if (cnt == last_beat(quad, 8'd24)) begin
                            cnt_d  = '0;
                            addr_d = sh_next[ADDR_W-1:0];
                            ocnt_d = '0;
                            if (!rd) begin
                                state_d = WDATA;
                            end else begin
                                re_d = 1'b1;
                                if (dmy) begin
                                    state_d = DUMMY;
                                end else begin
                                    state_d = RDATA;
                                    oen_d   = quad ? OE_QUAD : OE_SPI;
                                end
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        cnt_d = cnt + 8'd1;
                        if (cnt == 8'(WAIT_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = RDATA;
                            oen_d   = OE_QUAD;
                        end
                    end
                end
                RDATA: begin
                    if (sck_fall) begin
                        ocnt_d = ocnt + 3'd1;
                        if (quad) begin
                            out_d = ocnt[0] ? cur[3:0] : cur[7:4];
                            if (ocnt == 3'd1) begin
                                ocnt_d = '0;
                                re_d   = 1'b1;
                            end
                        end else begin
                            out_d = {2'b00, cur[3'd7 - ocnt], 1'b0};
                            if (ocnt == 3'd7) begin
                                ocnt_d = '0;
                                re_d   = 1'b1;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        sreg_d = sh_next;
                        cnt_d  = cnt + 8'd1;
                        if (cnt == last_beat(quad, 8'd8)) begin
                            cnt_d   = '0;
                            we_d    = 1'b1;
                            wdata_d = sh_next[7:0];
                        end
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Scoreboard bench for psram_qspi_responder: drives SPI/QPI transactions
// and checks memory strobes and returned read data.
module tb_psram_qspi_responder;

    localparam int HALF = 40;
    localparam int WAIT = 6;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        sck = 1'b0;
    logic        ce_n = 1'b1;
    logic [3:0]  sio_in = '0;
    logic [3:0]  sio_out;
    logic [3:0]  sio_outen;
    logic        qpi_mode;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int re_cnt = 0;

    logic [7:0]  mem [int];
    logic [31:0] wr_q [$];
    logic [7:0]  rd_q [$];

    psram_qspi_responder #(
        .ADDR_W(24),
        .WAIT_CYCLES(WAIT),
        .SYNC_STAGES(2)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .sck      (sck),
        .ce_n     (ce_n),
        .sio_in   (sio_in),
        .sio_out  (sio_out),
        .sio_outen(sio_outen),
        .qpi_mode (qpi_mode),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge HCLK) begin
        if (mem_re) begin
            mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
        end
        if (mem_we) begin
            mem[int'(mem_addr)] = mem_wdata;
        end
    end

    always @(negedge HCLK) begin
        logic [31:0] e;
        if (HRESETn) begin
            if (mem_we || mem_re) chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);
            if (mem_re) re_cnt++;
            if (mem_we) begin
                we_cnt++;
                chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[31:8]));
                    chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] d, output logic [3:0] q);
        sio_in = d;
        #HALF;
        q = sio_out;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic quad);
        logic [3:0] q;
        if (quad) begin
            cyc(b[7:4], q);
            cyc(b[3:0], q);
        end else begin
            for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]}, q);
        end
    endtask

    task automatic tx_addr(input logic [23:0] a, input logic quad);
        tx_byte(a[23:16], quad);
        tx_byte(a[15:8], quad);
        tx_byte(a[7:0], quad);
    endtask

    task automatic dummy();
        logic [3:0] q;
        repeat (WAIT) cyc(4'h0, q);
    endtask

    task automatic rx_byte(input logic quad, input string tag);
        logic [3:0] q;
        logic [7:0] b;
        logic [7:0] e;
        b = '0;
        if (quad) begin
            cyc(4'h0, q);
            b[7:4] = q;
            cyc(4'h0, q);
            b[3:0] = q;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                cyc(4'h0, q);
                b[i] = q[1];
            end
        end
        chk({tag, "_oen"}, 32'(sio_outen), quad ? 32'hF : 32'h2);
        e = rd_q.pop_front();
        chk(tag, 32'(b), 32'(e));
    endtask

    task automatic start();
        ce_n = 1'b0;
        #HALF;
    endtask

    task automatic stop();
        sio_in = '0;
        #HALF;
        ce_n = 1'b1;
        #(2*HALF);
    endtask

    task automatic exp_wr(input logic [23:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    initial begin
        int base_we;
        int base_re;
        logic [3:0] q;

        #30;
        chk("rst_sio_out", 32'(sio_out), 32'd0);
        chk("rst_oen", 32'(sio_outen), 32'd0);
        chk("rst_qpi", 32'(qpi_mode), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        HRESETn = 1'b1;
        #(2*HALF);

        // serial write then serial read
        start();
        tx_byte(8'h02, 1'b0);
        tx_addr(24'h000010, 1'b0);
        exp_wr(24'h000010, 8'hA5);
        exp_wr(24'h000011, 8'h3C);
        tx_byte(8'hA5, 1'b0);
        tx_byte(8'h3C, 1'b0);
        stop();
        chk("swr_drain", 32'(wr_q.size()), 32'd0);

        start();
        tx_byte(8'h03, 1'b0);
        tx_addr(24'h000010, 1'b0);
        rd_q.push_back(8'hA5);
        rd_q.push_back(8'h3C);
        rx_byte(1'b0, "srd0");
        rx_byte(1'b0, "srd1");
        stop();
        chk("srd_oen_off", 32'(sio_outen), 32'd0);

        // quad read with dummy cycles
        mem[32'h100] = 8'h12;
        mem[32'h101] = 8'h34;
        start();
        tx_byte(8'hEB, 1'b0);
        tx_addr(24'h000100, 1'b1);
        dummy();
        rd_q.push_back(8'h12);
        rd_q.push_back(8'h34);
        rx_byte(1'b1, "qrd0");
        rx_byte(1'b1, "qrd1");
        stop();

        // QPI entry, quad writes/reads in QPI, illegal 0x03 in QPI, exit
        start();
        tx_byte(8'h35, 1'b0);
        stop();
        chk("qpi_on", 32'(qpi_mode), 32'd1);

        start();
        tx_byte(8'h38, 1'b1);
        tx_addr(24'h000020, 1'b1);
        exp_wr(24'h000020, 8'h5A);
        tx_byte(8'h5A, 1'b1);
        stop();
        start();
        tx_byte(8'h02, 1'b1);
        tx_addr(24'h000030, 1'b1);
        exp_wr(24'h000030, 8'h77);
        tx_byte(8'h77, 1'b1);
        stop();
        chk("qpi_wr_drain", 32'(wr_q.size()), 32'd0);

        start();
        tx_byte(8'hEB, 1'b1);
        tx_addr(24'h000020, 1'b1);
        dummy();
        rd_q.push_back(8'h5A);
        rx_byte(1'b1, "qpi_rd");
        stop();

        base_re = re_cnt;
        start();
        tx_byte(8'h03, 1'b1);
        tx_addr(24'h000010, 1'b1);
        tx_byte(8'h00, 1'b1);
        chk("qpi03_oen", 32'(sio_outen), 32'd0);
        stop();
        chk("qpi03_re", 32'(re_cnt - base_re), 32'd0);

        start();
        tx_byte(8'hF5, 1'b1);
        stop();
        chk("qpi_off", 32'(qpi_mode), 32'd0);

        // address wrap on write and read
        start();
        tx_byte(8'h38, 1'b0);
        tx_addr(24'hFFFFFF, 1'b1);
        exp_wr(24'hFFFFFF, 8'h11);
        exp_wr(24'h000000, 8'h22);
        exp_wr(24'h000001, 8'h33);
        tx_byte(8'h11, 1'b1);
        tx_byte(8'h22, 1'b1);
        tx_byte(8'h33, 1'b1);
        stop();
        chk("wrap_drain", 32'(wr_q.size()), 32'd0);

        start();
        tx_byte(8'hEB, 1'b0);
        tx_addr(24'hFFFFFF, 1'b1);
        dummy();
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        rd_q.push_back(8'h33);
        rx_byte(1'b1, "wrap_rd0");
        rx_byte(1'b1, "wrap_rd1");
        rx_byte(1'b1, "wrap_rd2");
        stop();

        // abort after one nibble of a write byte
        base_we = we_cnt;
        start();
        tx_byte(8'h38, 1'b0);
        tx_addr(24'h000040, 1'b1);
        cyc(4'hA, q);
        stop();
        chk("abort_we", 32'(we_cnt - base_we), 32'd0);

        // abort mid-read
        start();
        tx_byte(8'h03, 1'b0);
        tx_addr(24'h000010, 1'b0);
        repeat (3) cyc(4'h0, q);
        chk("abort_rd_oen_on", 32'(sio_outen), 32'h2);
        #HALF;
        ce_n = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        chk("abort_rd_oen_off", 32'(sio_outen), 32'd0);
        chk("abort_rd_out", 32'(sio_out), 32'd0);
        #(2*HALF);

        start();
        tx_byte(8'h03, 1'b0);
        tx_addr(24'h000011, 1'b0);
        rd_q.push_back(8'h3C);
        rx_byte(1'b0, "post_abort_rd");
        stop();

        // illegal command followed by a burst
        base_we = we_cnt;
        base_re = re_cnt;
        start();
        tx_byte(8'h9F, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tx_byte(8'(8'hC0 + i), 1'b0);
            chk("ill_oen", 32'(sio_outen), 32'd0);
        end
        stop();
        chk("ill_we", 32'(we_cnt - base_we), 32'd0);
        chk("ill_re", 32'(re_cnt - base_re), 32'd0);

        start();
        tx_byte(8'h03, 1'b0);
        tx_addr(24'h000010, 1'b0);
        rd_q.push_back(8'hA5);
        rx_byte(1'b0, "post_ill_rd");
        stop();

        chk("final_wr_q", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
